// File: rtl/ws2812b_pkg.sv
// Shared encodings for the WS2812B strip driver: FSM states, register addresses, status bits.
// Pure declarations; no logic, no latency.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812b_strip_driver_if.sv
// Avalon-MM slave bundle for the strip driver; single-cycle writes, readdata one clock after read.
// No wait states, so there is no backpressure signal.
interface ws2812b_strip_driver_if;
  logic        address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, output writedata, output write, output read, input readdata);
  modport slave  (input address, input writedata, input write, input read, output readdata);
endinterface

// File: rtl/ws2812b_pixel_fifo.sv
// Show-ahead pixel FIFO: head visible combinationally, consumed on pop; flush empties it in one clock.
// Push while full is dropped unless a pop happens in the same cycle.
module ws2812b_pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign head_dat  = r_mem[r_rd_ptr];
  // When full, a simultaneous pop frees the slot the push is about to fill.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ws2812b_strip_driver.sv
// Self-timed WS2812B driver: Avalon regs, pixel FIFO, MSB-first serialiser, latch on underrun.
// data_out rises two clocks after the write that feeds an idle, enabled driver; writes never stall.
module ws2812b_strip_driver
  import ws2812b_pkg::*;
#(
  parameter int PIXEL_BITS = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 63,
  parameter int TRESET     = 2600
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ws2812b_strip_driver_if.slave  avs,
  output logic                   data_out,
  output logic                   frame_done
);

  localparam int CW = $clog2(max_int(TBIT, TRESET));
  localparam int BW = $clog2(PIXEL_BITS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] T0H_END    = CW'(T0H - 1);
  localparam logic [CW-1:0] T1H_END    = CW'(T1H - 1);
  localparam logic [CW-1:0] TBIT_END   = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRESET_END = CW'(TRESET - 1);
  localparam logic [BW-1:0] BIT_MSB    = BW'(PIXEL_BITS - 1);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [BW-1:0]         r_bit_idx, w_bit_idx_nxt;
  logic [PIXEL_BITS-1:0] r_shift, w_shift_nxt;
  logic                  r_enable;
  logic                  r_flush;
  logic                  r_overflow;
  logic [31:0]           r_readdata;
  logic                  r_data_out;
  logic                  r_latch_done;
  logic                  r_frame_done;

  logic                  w_pop;
  logic                  w_latch_done;
  logic                  w_wr_data;
  logic                  w_wr_ctrl;
  logic                  w_rd_status;
  logic                  w_ovf_set;
  logic [PIXEL_BITS-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [LW-1:0]         w_level;
  logic [31:0]           w_status;

  assign w_wr_data   = avs.write && (avs.address == ADDR_DATA);
  assign w_wr_ctrl   = avs.write && (avs.address == ADDR_CTRL);
  assign w_rd_status = avs.read && (avs.address == ADDR_DATA);
  assign w_ovf_set   = w_wr_data && w_full && !w_pop;

  ws2812b_pixel_fifo #(
    .WIDTH (PIXEL_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_wr_data),
    .push_dat (avs.writedata[PIXEL_BITS-1:0]),
    .pop      (w_pop),
    .flush    (r_flush),
    .head_dat (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .level    (w_level)
  );

  always_comb begin
    w_status                           = '0;
    w_status[STAT_EMPTY]               = w_empty;
    w_status[STAT_FULL]                = w_full;
    w_status[STAT_BUSY]                = (r_state != S_IDLE);
    w_status[STAT_OVERFLOW]            = r_overflow;
    w_status[STAT_LEVEL_LSB +: 8]      = 8'(w_level);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_flush    <= 1'b0;
      r_overflow <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_flush <= w_wr_ctrl && avs.writedata[CTRL_FLUSH];
      if (w_wr_ctrl) r_enable <= avs.writedata[CTRL_ENABLE];
      // A fresh overflow in the same cycle as the status read must not be lost.
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (w_rd_status) r_overflow <= 1'b0;
      if (avs.read)
        r_readdata <= (avs.address == ADDR_CTRL) ? {31'b0, r_enable} : w_status;
    end
  end

  assign avs.readdata = r_readdata;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_latch_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_enable && !w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_idx_nxt = BIT_MSB;
          w_state_nxt   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_cnt == (r_shift[PIXEL_BITS-1] ? T1H_END : T0H_END))
          w_state_nxt = S_LOW;
      end
      S_LOW: begin
        if (r_cnt == TBIT_END) begin
          w_cnt_nxt = '0;
          if (r_bit_idx != '0) begin
            w_shift_nxt   = r_shift << 1;
            w_bit_idx_nxt = r_bit_idx - 1'b1;
            w_state_nxt   = S_HIGH;
          end else if (r_enable && !w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_idx_nxt = BIT_MSB;
            w_state_nxt   = S_HIGH;
          end else begin
            w_state_nxt = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (r_cnt == TRESET_END) begin
          w_cnt_nxt    = '0;
          w_latch_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // data_out and frame_done both trail the state by one clock so they stay mutually aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data_out   <= 1'b0;
      r_latch_done <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_data_out   <= (r_state == S_HIGH);
      r_latch_done <= w_latch_done;
      r_frame_done <= r_latch_done;
    end
  end

  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;

endmodule

// File: doc/ws2812b_strip_driver.md
Name: ws2812b_strip_driver

Overview:
Parametrised, self-timed successor to the current WS2812B test chain. It merges the Avalon-MM slave, pixel FIFO, serialiser and bit-timing generator into one block, so it needs no external btrig/wtrig strobes.
- Pixel width (RGB/RGBW), FIFO depth and all bit/latch timings are parameters.
- Adds a status/control register, a sticky overflow flag, FIFO flush, automatic latch (reset) insertion on underrun, and a frame_done pulse.
- Sits between the Nios/Avalon fabric and one LED strip pin.

Parameters:
PIXEL_BITS, 24, bits per pixel (24 = GRB, 32 = GRBW); sent MSB first.
FIFO_DEPTH, 16, pixel FIFO entries; power of two, 2..128.
T0H, 20, clocks data_out is high for a '0' bit (0.4 us at 50 MHz).
T1H, 40, clocks data_out is high for a '1' bit (0.8 us at 50 MHz).
TBIT, 63, total clocks per bit; must satisfy TBIT > T1H > T0H > 0.
TRESET, 2600, clocks data_out is held low for latch (52 us at 50 MHz).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
address  in  1  0 = data/status, 1 = control.
writedata  in  32  Avalon write data.
write  in  1  Avalon write strobe, single cycle, no wait states.
read  in  1  Avalon read strobe.
readdata  out  32  registered; valid 1 clock after read.
data_out  out  1  serial strip output, registered.
frame_done  out  1  one-clock pulse when a latch period completes.

Behaviour:
- Reset (async, asserted): data_out=0, readdata=0, frame_done=0, FIFO empty, enable=0, overflow=0, FSM in IDLE, all counters 0.
- Register map:
  - Write address 0: push writedata[PIXEL_BITS-1:0] into the FIFO. If the FIFO is full, the data is dropped and overflow is set. A push and a pop in the same cycle while full is accepted.
  - Write address 1: bit0 = enable; bit1 = flush (self-clearing; empties the FIFO next clock).
  - Read address 0: [0] empty, [1] full, [2] busy (FSM != IDLE), [3] overflow, [15:8] fill level, other bits 0. Reading address 0 clears overflow; a same-cycle new overflow wins.
  - Read address 1: [0] enable, other bits 0.
- FIFO: show-ahead; the head word is visible combinationally and is consumed on pop.
- FSM states: IDLE, HIGH, LOW, LATCH.
  - IDLE: data_out=0. If enable && !empty: pop into shift register, bit_idx=PIXEL_BITS-1, cnt=0, go to HIGH.
  - HIGH: data_out=1. Leave when cnt reaches (msb ? T1H : T0H)-1; go to LOW.
  - LOW: data_out=0. At cnt = TBIT-1, end of bit:
    - If not the last bit: shift left, go to HIGH.
    - If the last bit and enable && !empty: pop the next pixel and go to HIGH. There are no gap cycles between pixels.
    - Otherwise go to LATCH.
  - LATCH: data_out=0 for TRESET clocks, then IDLE with frame_done=1 for one clock.
- cnt restarts at 0 at each bit start and spans HIGH+LOW, so every bit is exactly TBIT clocks. Counter width is clog2(max(TBIT,TRESET)).
- Latency: for a write at edge n with the FSM in IDLE and enable=1, data_out rises at edge n+2.
- Underrun (FIFO empty at a pixel boundary) ends the frame: forced LATCH. Software must refill faster than TRESET to avoid splitting a frame.
- Clearing enable mid-pixel: the current pixel completes, then LATCH. It never truncates a bit.
- Flush mid-pixel: the current pixel completes, then LATCH, because the FIFO is now empty.
- Async reset mid-bit: data_out drops to 0 immediately.

Decomposition:
- Package ws2812b_pkg holds the FSM state encoding, register address constants, and status bit positions.
- One sub-module, ws2812b_pixel_fifo: parameters WIDTH and DEPTH; show-ahead; ports push/pop/flush/full/empty/level. The FSM, shifter and Avalon decode stay in the top level.

Test Plan:
- Enable, then write 0xA5F00F → 24 bits; the first bit is high 40 clocks / low 23. Bit pattern 1010_0101_1111_0000_0000_1111. Then 2600 low clocks, then a frame_done pulse.
- Write two pixels 0xFFFFFF and 0x000000 back-to-back → 48 contiguous 63-clock bits with no gap clocks. Bits 25..48 are high 20 clocks each.
- With enable=0, write 17 pixels → status reads full=1, level=16, overflow=1. A second read of address 0 returns overflow=0; data_out stays 0.
- Enable with 3 pixels queued and clear enable during pixel 1 bit 5 → exactly 24 bits are sent, then LATCH; level stays 2.
- Write flush while streaming pixel 1 of 4 → pixel 1 completes, then LATCH; status reads empty=1, level=0.
- Assert reset_n=0 during a HIGH phase → data_out=0 in the same cycle. After release, status reads 0x00000001 and enable=0.
